// File: rtl/gate_response_checker.sv
// Checks a stream of observed {a,b,y} samples against an expected 2-input gate.
// Reports the vector count, the error count, input coverage and the first mismatch.
module gate_response_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op_sel,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_a,
    input  logic             s_b,
    input  logic             s_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [2:0]       first_err_vec
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    state_t           state;
    logic [1:0]       op_reg;
    logic [CNT_W-1:0] nv_reg;

    logic             handshake;
    logic             exp_y;
    logic             mismatch;
    logic [CNT_W-1:0] vec_inc;
    logic [CNT_W-1:0] err_next;
    logic [3:0]       cov_next;

    always_comb begin
        exp_y = 1'b0;
        case (op_reg)
            2'b00: exp_y = s_a & s_b;
            2'b01: exp_y = s_a | s_b;
            2'b10: exp_y = s_a ^ s_b;
            2'b11: exp_y = ~(s_a & s_b);
            default: exp_y = 1'b0;
        endcase
    end

    assign handshake = s_valid && s_ready;
    assign mismatch  = (s_y != exp_y);
    assign vec_inc   = vec_cnt + 1'b1;
    // Saturate rather than wrap so a huge failing run never reads as clean.
    assign err_next  = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + 1'b1 : err_cnt;

    always_comb begin
        cov_next = cov;
        cov_next[{s_a, s_b}] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            op_reg        <= '0;
            nv_reg        <= '0;
            s_ready       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            vec_cnt       <= '0;
            err_cnt       <= '0;
            cov           <= '0;
            first_err_idx <= '0;
            first_err_vec <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_reg        <= op_sel;
                        nv_reg        <= num_vectors;
                        vec_cnt       <= '0;
                        err_cnt       <= '0;
                        cov           <= '0;
                        first_err_idx <= '0;
                        first_err_vec <= '0;
                        pass          <= 1'b0;
                        if (num_vectors == '0) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            s_ready <= 1'b0;
                        end else begin
                            state   <= RUN;
                            done    <= 1'b0;
                            busy    <= 1'b1;
                            s_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (handshake) begin
                        vec_cnt <= vec_inc;
                        cov     <= cov_next;
                        err_cnt <= err_next;
                        // err_cnt never returns to zero within a run, so it marks the first miss.
                        if (mismatch && (err_cnt == '0)) begin
                            first_err_idx <= vec_cnt;
                            first_err_vec <= {s_a, s_b, s_y};
                        end
                        if (vec_inc == nv_reg) begin
                            state   <= DONE;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (err_next == '0) && (cov_next == 4'hF);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gate_response_checker.md
GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 SHALL provide parameter CNT_W, default 8, width of all vector/error counters and indices.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  single-cycle pulse; begins a check run.
REQ-006 op_sel  input  2  expected gate: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-007 num_vectors  input  CNT_W  vectors to accept per run.
REQ-008 s_valid  input  1  observed vector valid.
REQ-009 s_ready  output  1  checker accepts vector.
REQ-010 s_a, s_b, s_y  input  1 each  observed DUT inputs and output.
REQ-011 busy  output  1  run in progress.
REQ-012 done  output  1  run complete; held until next start.
REQ-013 pass  output  1  run passed; valid while done=1.
REQ-014 vec_cnt, err_cnt  output  CNT_W  accepted vectors, mismatches.
REQ-015 cov  output  4  bit {a,b} set when that input combination is seen.
REQ-016 first_err_idx  output  CNT_W  zero-based index of first mismatch.
REQ-017 first_err_vec  output  3  {a,b,y} of first mismatch.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-019 IDLE: s_ready=0, busy=0; start -> RUN; clear counters, cov, first_err_*, done, pass; latch op_sel and num_vectors.
REQ-020 start with num_vectors=0 -> DONE next cycle, pass=0.
REQ-021 RUN: s_ready=1, busy=1; handshake = s_valid && s_ready, at most one vector per cycle; no handshake -> no state change.
REQ-022 Per handshake: vec_cnt+1; cov[{s_a,s_b}] set; expected y from latched op_sel; s_y != expected -> err_cnt+1.
REQ-023 err_cnt SHALL saturate at 2^CNT_W-1; vec_cnt cannot wrap, since the run ends at num_vectors.
REQ-024 On first mismatch only: first_err_idx = vec_cnt before increment; first_err_vec = {s_a,s_b,s_y}; later mismatches do not overwrite.
REQ-025 Handshake making vec_cnt equal latched num_vectors -> DONE next cycle; s_ready drops that same next cycle.
REQ-026 DONE: done=1, busy=0, s_ready=0; pass = (err_cnt==0) && (cov==4'hF); counters hold.
REQ-027 start in DONE -> RUN (REQ-019 clearing applies); start in RUN ignored; op_sel/num_vectors changes in RUN ignored.
REQ-028 s_valid while s_ready=0 SHALL be ignored; no vector counted.

Reset
REQ-029 rst=1 SHALL immediately force IDLE and zero all outputs and internal registers, including mid-RUN.
REQ-030 After rst deasserts, the first start is honoured on the next rising edge.

Verification
REQ-031 Reset: rst pulse mid-RUN after 2 vectors -> same cycle: busy=0, s_ready=0, vec_cnt=0, cov=0, done=0.
REQ-032 AND, num_vectors=4, vectors (0,0,0),(0,1,0),(1,0,0),(1,1,1) back-to-back -> done=1 one cycle after 4th handshake, pass=1, err_cnt=0, cov=4'hF, vec_cnt=4.
REQ-033 AND, vectors (0,0,0),(0,1,0),(1,1,0),(1,0,1) -> err_cnt=2, first_err_idx=2, first_err_vec=3'b110, pass=0.
REQ-034 XOR, num_vectors=3, all correct, combos 00,01,10 -> cov=4'b0111, err_cnt=0, pass=0.
REQ-035 NAND, num_vectors=4, s_valid gaps of 0-3 idle cycles; start pulsed mid-RUN -> vec_cnt=4, no clear, pass=1.
REQ-036 num_vectors=0 start -> done=1 next cycle, pass=0, vec_cnt=0; then start again with num_vectors=4 -> counters cleared, RUN resumes.
